// File: rtl/eq2_bist.sv
// eq2_bist: exhaustive self-test sequencer for a 2-bit equality comparator.
// Sweeps all 16 (a,b) operand pairs, holds each for SETTLE cycles, then
// samples aeqb and counts mismatches against the ideal a==b result.
// Optional build macro EQ2_BIST_FAILCAP_EN adds first_fail/first_fail_vld,
// which record the vector index of the first mismatch in a sweep.
//
// state | meaning
// IDLE  | waiting for start, operands parked at 0
// RUN   | current vector driven, settle counter running
// CHECK | aeqb sampled and compared, advance to next vector
// FIN   | publish done/pass, return to IDLE
module eq2_bist #(
    parameter int SETTLE = 2
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    output logic [1:0] a,
    output logic [1:0] b,
    input  logic       aeqb,
    output logic       busy,
    output logic       done,
    output logic       pass,
    output logic [4:0] err_cnt
`ifdef EQ2_BIST_FAILCAP_EN
    ,
    output logic [3:0] first_fail,
    output logic       first_fail_vld
`endif
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        CHECK = 2'd2,
        FIN   = 2'd3
    } state_t;

    localparam logic [3:0] SETTLE_LAST = 4'(SETTLE - 1);

    state_t     state;
    state_t     state_nxt;
    logic [3:0] vec;
    logic [3:0] settle_cnt;
    logic       mismatch;

    // The ideal comparator says equal only when both operand halves match.
    assign mismatch = (aeqb != (vec[3:2] == vec[1:0]));

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state decode and operand/status outputs.
    always_comb begin
        state_nxt = state;
        busy      = 1'b1;
        a         = vec[3:2];
        b         = vec[1:0];
        case (state)
            IDLE: begin
                busy = 1'b0;
                a    = 2'b00;
                b    = 2'b00;
                if (start) begin
                    state_nxt = RUN;
                end
            end
            RUN: begin
                if (settle_cnt == SETTLE_LAST) begin
                    state_nxt = CHECK;
                end
            end
            CHECK: begin
                state_nxt = (vec == 4'd15) ? FIN : RUN;
            end
            FIN: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Sweep datapath: vector index, settle counter, error tally and results.
    always_ff @(posedge clk) begin
        if (reset) begin
            vec        <= 4'd0;
            settle_cnt <= 4'd0;
            err_cnt    <= 5'd0;
            done       <= 1'b0;
            pass       <= 1'b0;
`ifdef EQ2_BIST_FAILCAP_EN
            first_fail     <= 4'd0;
            first_fail_vld <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        vec        <= 4'd0;
                        settle_cnt <= 4'd0;
                        err_cnt    <= 5'd0;
                        done       <= 1'b0;
                        pass       <= 1'b0;
`ifdef EQ2_BIST_FAILCAP_EN
                        first_fail     <= 4'd0;
                        first_fail_vld <= 1'b0;
`endif
                    end
                end
                RUN: begin
                    if (settle_cnt == SETTLE_LAST) begin
                        settle_cnt <= 4'd0;
                    end else begin
                        settle_cnt <= settle_cnt + 4'd1;
                    end
                end
                CHECK: begin
                    if (mismatch) begin
                        err_cnt <= err_cnt + 5'd1;
`ifdef EQ2_BIST_FAILCAP_EN
                        if (!first_fail_vld) begin
                            first_fail     <= vec;
                            first_fail_vld <= 1'b1;
                        end
`endif
                    end
                    if (vec != 4'd15) begin
                        vec <= vec + 4'd1;
                    end
                end
                FIN: begin
                    done <= 1'b1;
                    pass <= (err_cnt == 5'd0);
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_eq2_bist.sv
// tb_eq2_bist: randomized self-checking bench for eq2_bist. Two instances
// (SETTLE=2 and SETTLE=1) share start/reset and a configurable faulty
// comparator; the expected sweep is computed from plain arithmetic over the
// 16 operand pairs. Build with EQ2_BIST_FAILCAP_EN to also check first_fail.
module tb_eq2_bist;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       start = 1'b0;
    int         mode = 0;       // 0: mask-faulted comparator, 1: stuck 0, 2: stuck 1
    logic [15:0] fault_mask = 16'h0;
    logic       sel = 1'b0;     // 0 observes SETTLE=2 instance, 1 observes SETTLE=1

    logic [1:0] a2, b2, a1, b1;
    logic       aeqb2, aeqb1;
    logic       busy2, done2, pass2, busy1, done1, pass1;
    logic [4:0] err2, err1;
    logic [3:0] ff2, ff1;
    logic       ffv2, ffv1;

    logic [1:0] o_a, o_b;
    logic       o_busy, o_done, o_pass, o_ffv;
    logic [4:0] o_err;
    logic [3:0] o_ff;

    int n_cmp = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    assign aeqb2 = (mode == 1) ? 1'b0 : (mode == 2) ? 1'b1 : ((a2 == b2) ^ fault_mask[{a2, b2}]);
    assign aeqb1 = (mode == 1) ? 1'b0 : (mode == 2) ? 1'b1 : ((a1 == b1) ^ fault_mask[{a1, b1}]);

`ifndef EQ2_BIST_FAILCAP_EN
    assign ff2 = 4'd0;
    assign ffv2 = 1'b0;
    assign ff1 = 4'd0;
    assign ffv1 = 1'b0;
`endif

    eq2_bist #(.SETTLE(2)) dut2 (
        .clk(clk), .reset(reset), .start(start), .a(a2), .b(b2), .aeqb(aeqb2),
        .busy(busy2), .done(done2), .pass(pass2), .err_cnt(err2)
`ifdef EQ2_BIST_FAILCAP_EN
        , .first_fail(ff2), .first_fail_vld(ffv2)
`endif
    );

    eq2_bist #(.SETTLE(1)) dut1 (
        .clk(clk), .reset(reset), .start(start), .a(a1), .b(b1), .aeqb(aeqb1),
        .busy(busy1), .done(done1), .pass(pass1), .err_cnt(err1)
`ifdef EQ2_BIST_FAILCAP_EN
        , .first_fail(ff1), .first_fail_vld(ffv1)
`endif
    );

    assign o_a    = sel ? a1 : a2;
    assign o_b    = sel ? b1 : b2;
    assign o_busy = sel ? busy1 : busy2;
    assign o_done = sel ? done1 : done2;
    assign o_pass = sel ? pass1 : pass2;
    assign o_err  = sel ? err1 : err2;
    assign o_ff   = sel ? ff1 : ff2;
    assign o_ffv  = sel ? ffv1 : ffv2;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        start = 1'b0;
        tick();
        reset = 1'b0;
    endtask

    // Full sweep on instance with settle s; optionally re-pulse start mid-run
    // or hold start across the FIN edge and one cycle beyond.
    task automatic run_sweep(input int s, input int mode_i, input logic [15:0] mask_i,
                             input bit repulse, input bit b2b, input string tag);
        int last;
        int exp_err;
        int exp_first;
        int v;
        bit got;
        last = 16 * (s + 1);
        mode = mode_i;
        fault_mask = mask_i;
        sel = (s == 1);
        exp_err = 0;
        exp_first = -1;
        for (int i = 0; i < 16; i++) begin
            bit ideal;
            ideal = ((i / 4) == (i % 4));
            if (mode_i == 1) got = 1'b0;
            else if (mode_i == 2) got = 1'b1;
            else got = ideal ^ mask_i[i];
            if (got != ideal) begin
                exp_err++;
                if (exp_first < 0) exp_first = i;
            end
        end
        do_reset();
        start = 1'b1;
        tick();
        start = 1'b0;
        n_cmp++;
        if (o_busy !== 1'b1 || o_a !== 2'b00 || o_b !== 2'b00 || o_done !== 1'b0 || o_err !== 5'd0) begin
            n_fail++;
            $display("FAIL %s accept: busy=%b a=%b b=%b done=%b err=%0d, required busy=1 a=00 b=00 done=0 err=0",
                     tag, o_busy, o_a, o_b, o_done, o_err);
        end
        for (int k = 1; k <= last + 1; k++) begin
            start = (repulse && (k == 10 || k == 30)) || (b2b && k == last + 1);
            tick();
            if (!(b2b && k == last + 1)) start = 1'b0;
            if (k < last) begin
                v = k / (s + 1);
                n_cmp++;
                if (o_a !== 2'(v / 4) || o_b !== 2'(v % 4) || o_busy !== 1'b1 || o_done !== 1'b0) begin
                    n_fail++;
                    $display("FAIL %s cycle %0d: a=%b b=%b busy=%b done=%b, required a=%0d b=%0d busy=1 done=0",
                             tag, k, o_a, o_b, o_busy, o_done, v / 4, v % 4);
                end
            end else if (k == last) begin
                n_cmp++;
                if (o_busy !== 1'b1 || o_done !== 1'b0) begin
                    n_fail++;
                    $display("FAIL %s fin cycle %0d: busy=%b done=%b, required busy=1 done=0",
                             tag, k, o_busy, o_done);
                end
            end else begin
                n_cmp++;
                if (o_busy !== 1'b0 || o_done !== 1'b1 || o_pass !== (exp_err == 0) || o_err !== 5'(exp_err)) begin
                    n_fail++;
                    $display("FAIL %s done cycle %0d: busy=%b done=%b pass=%b err=%0d, required busy=0 done=1 pass=%0d err=%0d",
                             tag, k, o_busy, o_done, o_pass, o_err, exp_err == 0, exp_err);
                end
`ifdef EQ2_BIST_FAILCAP_EN
                n_cmp++;
                if (o_ffv !== (exp_first >= 0) || o_ff !== ((exp_first >= 0) ? 4'(exp_first) : 4'd0)) begin
                    n_fail++;
                    $display("FAIL %s first_fail: vld=%b ff=%0d, required vld=%0d ff=%0d",
                             tag, o_ffv, o_ff, exp_first >= 0, (exp_first >= 0) ? exp_first : 0);
                end
`endif
            end
        end
        if (b2b) begin
            tick();
            start = 1'b0;
            n_cmp++;
            if (o_busy !== 1'b1 || o_done !== 1'b0 || o_err !== 5'd0 || o_a !== 2'b00) begin
                n_fail++;
                $display("FAIL %s restart: busy=%b done=%b err=%0d a=%b, required busy=1 done=0 err=0 a=00",
                         tag, o_busy, o_done, o_err, o_a);
            end
        end
        do_reset();
    endtask

    task automatic test_reset();
        sel = 1'b0;
        mode = 0;
        fault_mask = 16'h0;
        start = 1'b1;
        reset = 1'b1;
        tick();
        start = 1'b0;
        reset = 1'b0;
        n_cmp++;
        if (o_busy !== 1'b0 || o_done !== 1'b0 || o_pass !== 1'b0 || o_err !== 5'd0 ||
            o_a !== 2'b00 || o_b !== 2'b00 || o_ff !== 4'd0 || o_ffv !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_state: busy=%b done=%b pass=%b err=%0d a=%b b=%b ff=%0d vld=%b, required all 0",
                     o_busy, o_done, o_pass, o_err, o_a, o_b, o_ff, o_ffv);
        end
    endtask

    task automatic test_correct();
        run_sweep(2, 0, 16'h0, 1'b0, 1'b0, "settle2_good");
        run_sweep(1, 0, 16'h0, 1'b0, 1'b0, "settle1_good");
    endtask

    task automatic test_stuck();
        run_sweep(2, 1, 16'h0, 1'b0, 1'b0, "stuck0");
        run_sweep(2, 2, 16'h0, 1'b0, 1'b0, "stuck1");
    endtask

    task automatic test_random_faults();
        for (int i = 0; i < 4; i++) begin
            logic [15:0] m;
            m = 16'($urandom);
            if (i == 0) m = 16'h0;
            run_sweep((i % 2 == 0) ? 2 : 1, 0, m, 1'b0, 1'b0, "rand_mask");
        end
    endtask

    task automatic test_repulse();
        run_sweep(2, 0, 16'($urandom), 1'b1, 1'b0, "repulse");
    endtask

    task automatic test_back_to_back();
        run_sweep(2, 0, 16'h0, 1'b0, 1'b1, "back_to_back");
    endtask

    task automatic test_mid_reset();
        sel = 1'b0;
        mode = 0;
        fault_mask = 16'hffff;
        do_reset();
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int k = 1; k <= 15; k++) tick();
        n_cmp++;
        if (o_a !== 2'b01 || o_b !== 2'b01 || o_busy !== 1'b1) begin
            n_fail++;
            $display("FAIL mid_reset_pre: a=%b b=%b busy=%b, required a=01 b=01 busy=1", o_a, o_b, o_busy);
        end
        reset = 1'b1;
        tick();
        reset = 1'b0;
        n_cmp++;
        if (o_busy !== 1'b0 || o_done !== 1'b0 || o_pass !== 1'b0 || o_err !== 5'd0 ||
            o_a !== 2'b00 || o_b !== 2'b00 || o_ff !== 4'd0 || o_ffv !== 1'b0) begin
            n_fail++;
            $display("FAIL mid_reset: busy=%b done=%b pass=%b err=%0d a=%b b=%b ff=%0d vld=%b, required all 0",
                     o_busy, o_done, o_pass, o_err, o_a, o_b, o_ff, o_ffv);
        end
        tick();
        n_cmp++;
        if (o_done !== 1'b0 || o_busy !== 1'b0) begin
            n_fail++;
            $display("FAIL mid_reset_idle: busy=%b done=%b, required busy=0 done=0", o_busy, o_done);
        end
        run_sweep(2, 0, 16'h0, 1'b0, 1'b0, "after_reset");
    endtask

    initial begin
        test_reset();
        test_correct();
        test_stuck();
        test_random_faults();
        test_repulse();
        test_back_to_back();
        test_mid_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/eq2_bist.md
EQ2_BIST -- requirements
Module: eq2_bist

Interface
REQ-001 The block SHALL have parameter SETTLE, default 2, giving the number of cycles each vector is driven before aeqb is sampled; legal range 1..15.
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-003 The block SHALL have port reset, input, 1 bit: reset, synchronous and active-high.
REQ-004 The block SHALL have port start, input, 1 bit: one-cycle request to run the test sweep.
REQ-005 The block SHALL have port a, output, 2 bits: the first operand driven to the comparator under test.
REQ-006 The block SHALL have port b, output, 2 bits: the second operand driven to the comparator under test.
REQ-007 The block SHALL have port aeqb, input, 1 bit: the equality result returned by the comparator under test.
REQ-008 The block SHALL have port busy, output, 1 bit: high while a sweep is in progress.
REQ-009 The block SHALL have port done, output, 1 bit: high after a sweep completes; held until the next accepted start.
REQ-010 The block SHALL have port pass, output, 1 bit: high with done when the mismatch count is zero.
REQ-011 The block SHALL have port err_cnt, output, 5 bits: the number of mismatching vectors in the current or last sweep (0..16).

Function
REQ-012 The block SHALL implement the states IDLE, RUN, CHECK and FIN, plus a 4-bit vector index vec and a settle counter.
REQ-013 Vector vec SHALL be applied as a = vec[3:2] and b = vec[1:0]; in IDLE, a and b SHALL be 2'b00.
REQ-014 In IDLE, start=1 SHALL cause a move to RUN with vec=0, settle counter=0, err_cnt=0, done=0 and pass=0.
REQ-015 In RUN, the settle counter SHALL increment each cycle, and the block SHALL move to CHECK on the cycle the counter equals SETTLE-1, clearing the counter.
REQ-016 In CHECK, the block SHALL sample aeqb; a mismatch SHALL be counted when aeqb != (vec[3:2]==vec[1:0]), with err_cnt incremented by 1 (no overflow is possible).
REQ-017 In CHECK with vec != 15, the block SHALL increment vec and return to RUN; with vec == 15, it SHALL move to FIN.
REQ-018 In FIN, the block SHALL set done=1 and pass=(final err_cnt==0), including the last CHECK result, and move to IDLE.
REQ-019 Each vector SHALL occupy exactly SETTLE+1 cycles; done SHALL rise 16*(SETTLE+1)+1 cycles after the edge that accepts start (49 cycles for SETTLE=2).
REQ-020 busy SHALL be 1 in RUN, CHECK and FIN, and 0 in IDLE.
REQ-021 start SHALL be ignored while busy=1.
REQ-022 A start in the same cycle that FIN returns to IDLE SHALL be ignored; a start one cycle later SHALL be accepted.
REQ-023 a and b SHALL stay stable for the whole RUN+CHECK window of each vector.

Reset
REQ-024 While reset=1, at the clock edge the block SHALL enter IDLE with vec=0, counter=0, a=b=0, busy=0, done=0, pass=0, err_cnt=0, and with the macro-enabled outputs also cleared.
REQ-025 Reset asserted mid-sweep SHALL abort the sweep immediately, without asserting done; the next accepted start SHALL restart from vec=0.
REQ-026 reset SHALL take priority over start.

Configuration
REQ-027 With macro EQ2_BIST_FAILCAP_EN defined, the block SHALL add output first_fail (4 bits, the vec of the first mismatch in a sweep) and output first_fail_vld (1 bit).
REQ-028 With EQ2_BIST_FAILCAP_EN defined, first_fail and first_fail_vld SHALL be captured at the first mismatching CHECK only and held until the next accepted start or reset, which clear both to 0.
REQ-029 Without EQ2_BIST_FAILCAP_EN, the ports first_fail and first_fail_vld SHALL not exist, and all other behaviour SHALL be identical.

Verification
REQ-030 The bench SHALL cover: SETTLE=2 with a correct comparator model, start pulse -> busy for 48 cycles, then done=1, pass=1, err_cnt=0 at cycle 49.
REQ-031 The bench SHALL cover: aeqb stuck at 0 -> err_cnt=4, pass=0; with the macro, first_fail=4'h0 and first_fail_vld=1.
REQ-032 The bench SHALL cover: aeqb stuck at 1 -> err_cnt=12, pass=0; with the macro, first_fail=4'h1.
REQ-033 The bench SHALL cover: start re-pulsed at cycles 10 and 30 of a run -> no restart, a/b sequence unchanged, done still at cycle 49.
REQ-034 The bench SHALL cover: reset at vector 5 (a=01, b=01) -> next cycle all outputs 0 and busy=0; a new start sweeps from a=00, b=00.
REQ-035 The bench SHALL cover: SETTLE=1 with a correct model -> each vector held 2 cycles, done at cycle 33, pass=1.
